// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner: per-frame input snapshot, leading-zero blanking,
// per-digit dp/blink, and PWM brightness with one dead cycle at the start of each slot.
module seg_scan_ctrl #(
    parameter int DIGITS         = 6,
    parameter int CLK_DIV        = 1000,
    parameter int PWM_BITS       = 4,
    parameter int BLINK_LOG2     = 6,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int CS_ACTIVE_LOW  = 1
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic [5*DIGITS-1:0] digit_data,
    input  logic [DIGITS-1:0]   dp,
    input  logic [DIGITS-1:0]   blink_mask,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic                lz_suppress,
    output logic [7:0]          seg_data,
    output logic [DIGITS-1:0]   seg_cs,
    output logic                frame_start
);
    localparam int PRE_W   = $clog2(CLK_DIV);
    localparam int SLOT_W  = $clog2(DIGITS);
    localparam int FRAME_W = BLINK_LOG2 + 1;
    localparam logic [7:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] CS_OFF  = (CS_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [PRE_W-1:0]    pre_cnt_r;
    logic [SLOT_W-1:0]   slot_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [FRAME_W-1:0]  frame_cnt_r;

    logic [5*DIGITS-1:0] snap_data_r;
    logic [DIGITS-1:0]   snap_dp_r;
    logic [DIGITS-1:0]   snap_blink_r;
    logic [PWM_BITS-1:0] snap_bright_r;
    logic                snap_lz_r;

    logic                pre_wrap_s;
    logic                slot_wrap_s;
    logic                frame_s;
    logic                en_s;
    logic                leading_s;
    logic [DIGITS-1:0]   lz_mask_s;
    logic [4:0]          cur_code_s;
    logic                cur_dp_s;
    logic                cur_blank_s;
    logic [7:0]          seg_s;
    logic [DIGITS-1:0]   cs_s;

    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        case (code)
            5'h00:   seg_decode = 7'h3F;
            5'h01:   seg_decode = 7'h06;
            5'h02:   seg_decode = 7'h5B;
            5'h03:   seg_decode = 7'h4F;
            5'h04:   seg_decode = 7'h66;
            5'h05:   seg_decode = 7'h6D;
            5'h06:   seg_decode = 7'h7D;
            5'h07:   seg_decode = 7'h07;
            5'h08:   seg_decode = 7'h7F;
            5'h09:   seg_decode = 7'h6F;
            5'h0A:   seg_decode = 7'h77;
            5'h0B:   seg_decode = 7'h7C;
            5'h0C:   seg_decode = 7'h39;
            5'h0D:   seg_decode = 7'h5E;
            5'h0E:   seg_decode = 7'h79;
            5'h0F:   seg_decode = 7'h71;
            5'h11:   seg_decode = 7'h40;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    assign pre_wrap_s  = (pre_cnt_r == PRE_W'(CLK_DIV - 1));
    assign slot_wrap_s = (slot_r == SLOT_W'(DIGITS - 1));
    assign frame_s     = (pre_cnt_r == {PRE_W{1'b0}}) && (slot_r == {SLOT_W{1'b0}});
    // pre_cnt==0 is the dead cycle of every slot, so selects never straddle a digit change
    assign en_s        = (pre_cnt_r != {PRE_W{1'b0}}) && (pwm_cnt_r <= snap_bright_r);

    // Scan timing counters: prescaler, slot index, PWM phase and frame count
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pre_cnt_r   <= {PRE_W{1'b0}};
            slot_r      <= {SLOT_W{1'b0}};
            pwm_cnt_r   <= {PWM_BITS{1'b0}};
            frame_cnt_r <= {FRAME_W{1'b0}};
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
            if (pre_wrap_s) begin
                pre_cnt_r <= {PRE_W{1'b0}};
                if (slot_wrap_s) begin
                    slot_r      <= {SLOT_W{1'b0}};
                    frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
                end else begin
                    slot_r <= slot_r + SLOT_W'(1);
                end
            end else begin
                pre_cnt_r <= pre_cnt_r + PRE_W'(1);
            end
        end
    end

    // Frame-coherent copy of all display inputs, taken at the start of slot 0
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            snap_data_r   <= {DIGITS{5'h10}};
            snap_dp_r     <= {DIGITS{1'b0}};
            snap_blink_r  <= {DIGITS{1'b0}};
            snap_bright_r <= {PWM_BITS{1'b1}};
            snap_lz_r     <= 1'b0;
        end else if (frame_s) begin
            snap_data_r   <= digit_data;
            snap_dp_r     <= dp;
            snap_blink_r  <= blink_mask;
            snap_bright_r <= brightness;
            snap_lz_r     <= lz_suppress;
        end else begin
            snap_data_r   <= snap_data_r;
        end
    end

    // Leading-zero mask: blank zero fields from the top until the first non-zero one
    always_comb begin
        lz_mask_s = {DIGITS{1'b0}};
        leading_s = snap_lz_r;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (leading_s && (snap_data_r[5*k +: 5] == 5'h00)) begin
                lz_mask_s[k] = 1'b1;
            end else begin
                leading_s = 1'b0;
            end
        end
    end

    // Current-slot field selection and select-line generation (slot k drives cs bit DIGITS-1-k)
    always_comb begin
        cur_code_s  = 5'h10;
        cur_dp_s    = 1'b0;
        cur_blank_s = 1'b1;
        cs_s        = {DIGITS{1'b0}};
        for (int k = 0; k < DIGITS; k++) begin
            if (slot_r == SLOT_W'(k)) begin
                cur_code_s         = snap_data_r[5*k +: 5];
                cur_dp_s           = snap_dp_r[k];
                cur_blank_s        = lz_mask_s[k] || (frame_cnt_r[BLINK_LOG2] && snap_blink_r[k]);
                cs_s[DIGITS-1-k]   = en_s;
            end else begin
                cs_s[DIGITS-1-k]   = 1'b0;
            end
        end
    end

    // Segment pattern, forced blank whenever no select is active
    always_comb begin
        if (en_s && !cur_blank_s) begin
            seg_s = {cur_dp_s, seg_decode(cur_code_s)};
        end else begin
            seg_s = 8'h00;
        end
    end

    // Registered outputs with polarity applied
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            seg_data    <= SEG_OFF;
            seg_cs      <= CS_OFF;
            frame_start <= 1'b0;
        end else begin
            seg_data    <= seg_s ^ SEG_OFF;
            seg_cs      <= cs_s ^ CS_OFF;
            frame_start <= frame_s;
        end
    end
endmodule
